wram_write_arbiter: RTL and testbench
=====================================

# wram_write_arbiter

Arbitrates the single write port of the weight/distance RAM (`wram`) among three requesters: the controller's initialisation writer (port 0), the relaxation datapath (port 1), and the host/debug loader (port 2). Each requester uses a valid/accept handshake. The winner's address and data are registered and driven onto `wram`'s `WE`/`WriteAddress`/`WriteBus`. The block supports short locked bursts and keeps a saturating contention counter for performance debug.

## Interface
- `ADDR_W`, 13: wram write address width
- `DATA_W`, 128: wram line width
- `MAX_BURST`, 4: maximum consecutive beats a locked owner may hold the grant while others wait (≥1)

- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `req`  in  3  per-requester write valid
- `lock`  in  3  per-requester burst hold request; meaningful only with matching `req`
- `addr0`, `addr1`, `addr2`  in  ADDR_W  write address per requester
- `data0`, `data1`, `data2`  in  DATA_W  write data per requester
- `gnt`  out  3  one-hot accept, combinational; a beat transfers when `req[i] && gnt[i]`
- `WE`  out  1  registered wram write enable
- `wa`  out  ADDR_W  registered wram write address
- `write_value`  out  DATA_W  registered wram write data
- `owner`  out  2  index of last granted requester (registered)
- `collide_clr`  in  1  synchronous clear of `collide_cnt`
- `collide_cnt`  out  16  saturating count of cycles with ≥2 `req` bits set

## Operation
- At most one `gnt` bit is high per cycle. `gnt` is 0 when `req` is 0 and while `reset` is low.
- Priority order is round-robin, starting at `(owner+1) mod 3` and wrapping through 0..2.
- Lock rule:
  - If `req[owner] && lock[owner]` and `burst_cnt < MAX_BURST`, `owner` wins regardless of rotation.
  - Once `burst_cnt == MAX_BURST`, the lock is ignored for one arbitration and normal rotation applies.
  - If no other requester is active at that point, `owner` is re-granted and `burst_cnt` restarts at 1.
- `burst_cnt` (internal, `clog2(MAX_BURST+1)` bits) updates on each granted beat:
  - Set to 1 when the grantee differs from `owner`, or when the owner's `lock` was low on the previous beat.
  - Otherwise increments.
  - Holds on cycles with no grant. The lock state is preserved across idle cycles only if `lock[owner]` stays high.
- `owner` updates to the grantee on every granted cycle and holds otherwise.
- Per-cycle write outputs:
  - On a grant: `WE <= 1`, `wa <= addrN`, `write_value <= dataN`, where N is the grantee.
  - With no grant: `WE <= 0`; `wa` and `write_value` hold their last value.
- `collide_cnt`:
  - Increments when `popcount(req) ≥ 2`, saturating at 16'hFFFF.
  - `collide_clr` takes precedence over the increment and loads 0.
- No requester is ever starved. With `MAX_BURST` ≥1 and round-robin, the worst-case wait is `2*MAX_BURST` cycles.

## Timing
- Reset values: `WE=0`, `wa=0`, `write_value=0`, `owner=2` (so requester 0 has first priority), `burst_cnt=0`, `collide_cnt=0`, `gnt=0`.
- Grant is combinational: `gnt` is valid in the same cycle as `req`.
- Write latency is one cycle. A beat accepted in cycle t appears on `WE`/`wa`/`write_value` in cycle t+1.
- Throughput is one beat per cycle, and back-to-back grants to different requesters are allowed.
- Requesters must hold `req`/`addr`/`data` stable until `gnt`. Dropping `req` without `gnt` is legal and simply withdraws the request.
- Asserting `reset` mid-burst clears all state immediately. No partial write is issued after reset release.

## Configuration
- `WARB_FIXED_PRIORITY_EN` defined:
  - Rotation is replaced by fixed priority, port 0 > port 1 > port 2.
  - The lock and `MAX_BURST` rules still apply, so a locked lower-priority owner keeps the port until its burst limit.
  - `owner` still reports the last grantee.
- Undefined: round-robin as specified above.

## Test plan
- Reset release, `req=3'b001`, `addr0=13'h0A5`, `data0=128'h1` → `gnt=001` same cycle; next cycle `WE=1`, `wa=13'h0A5`, `write_value=128'h1`, `owner=0`.
- `req=3'b111` held for 6 cycles, no locks → grant sequence 0,1,2,0,1,2; `collide_cnt=6`.
- `req=3'b011` with `lock[1]=1` from the cycle requester 1 is first granted, `MAX_BURST=4` → four consecutive port-1 grants, then one port-0 grant, then port 1 again.
- `req=3'b100` with `lock[2]=1` alone for 10 cycles → 10 consecutive port-2 grants; `burst_cnt` restarts at 1 after each 4.
- `collide_cnt` preloaded to 16'hFFFE, `req=3'b110` for 3 cycles → saturates at 16'hFFFF; `collide_clr=1` with `req=3'b110` → 0.
- `reset` driven low mid-burst while `WE=1` → `WE`, `gnt`, `owner` return to 0, 0, 2 asynchronously; with `WARB_FIXED_PRIORITY_EN`, `req=3'b111` → port 0 granted every cycle.

Source files
------------

// File: rtl/wram_write_arbiter.sv
// Write-port arbiter for wram: three valid/accept requesters, lockable bursts, registered write.
// Define WARB_FIXED_PRIORITY_EN to replace round-robin rotation with fixed priority 0 > 1 > 2.
module wram_write_arbiter #(
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 128,
    parameter int MAX_BURST = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [2:0]        req,
    input  logic [2:0]        lock,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    output logic [2:0]        gnt,
    output logic              WE,
    output logic [ADDR_W-1:0] wa,
    output logic [DATA_W-1:0] write_value,
    output logic [1:0]        owner,
    input  logic              collide_clr,
    output logic [15:0]       collide_cnt
);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] MAX_B = BW'(MAX_BURST);

    logic [BW-1:0]     burst_cnt;
    logic              lock_prev;
    logic [1:0]        start_p0;
    logic [1:0]        cand1_p0;
    logic [1:0]        cand2_p0;
    logic              lock_hit_p0;
    logic              vld_p0;
    logic [1:0]        gidx_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] data_p0;
    logic              multi_req_p0;

    function automatic logic [1:0] next3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Arbitration stage (combinational, same cycle as req)
`ifdef WARB_FIXED_PRIORITY_EN
    assign start_p0 = 2'd0;
`else
    assign start_p0 = next3(owner);
`endif
    assign cand1_p0     = next3(start_p0);
    assign cand2_p0     = next3(cand1_p0);
    assign lock_hit_p0  = req[owner] && lock[owner] && (burst_cnt < MAX_B);
    assign multi_req_p0 = (req[0] & req[1]) | (req[0] & req[2]) | (req[1] & req[2]);

    always_comb begin
        vld_p0  = 1'b1;
        gidx_p0 = owner;
        if (lock_hit_p0)
            gidx_p0 = owner;
        else if (req[start_p0])
            gidx_p0 = start_p0;
        else if (req[cand1_p0])
            gidx_p0 = cand1_p0;
        else if (req[cand2_p0])
            gidx_p0 = cand2_p0;
        else
            vld_p0 = 1'b0;
        if (!reset)
            vld_p0 = 1'b0;
    end

    always_comb begin
        gnt = 3'b000;
        if (vld_p0)
            gnt[gidx_p0] = 1'b1;
    end

    always_comb begin
        case (gidx_p0)
            2'd0:    begin addr_p0 = addr0; data_p0 = data0; end
            2'd1:    begin addr_p0 = addr1; data_p0 = data1; end
            default: begin addr_p0 = addr2; data_p0 = data2; end
        endcase
    end

    // Write register stage (one-cycle latency onto wram)
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            WE          <= 1'b0;
            wa          <= '0;
            write_value <= '0;
            owner       <= 2'd2;
            burst_cnt   <= '0;
            lock_prev   <= 1'b0;
            collide_cnt <= '0;
        end else begin
            if (vld_p0) begin
                WE          <= 1'b1;
                wa          <= addr_p0;
                write_value <= data_p0;
                owner       <= gidx_p0;
                lock_prev   <= lock[gidx_p0];
                // A new owner, an unlocked previous beat or an exhausted burst starts a fresh count.
                if (gidx_p0 != owner || !lock_prev || burst_cnt >= MAX_B)
                    burst_cnt <= BW'(1);
                else
                    burst_cnt <= burst_cnt + BW'(1);
            end else begin
                WE        <= 1'b0;
                lock_prev <= lock_prev & lock[owner];
            end

            if (collide_clr)
                collide_cnt <= '0;
            else if (multi_req_p0 && collide_cnt != 16'hFFFF)
                collide_cnt <= collide_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_wram_write_arbiter.sv
// Scoreboard bench for wram_write_arbiter: random and directed stimulus against a behavioural model.
module tb_wram_write_arbiter;
    localparam int ADDR_W    = 13;
    localparam int DATA_W    = 128;
    localparam int MAX_BURST = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [2:0]        req = 3'b000;
    logic [2:0]        lock = 3'b000;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0, addr2 = '0;
    logic [DATA_W-1:0] data0 = '0, data1 = '0, data2 = '0;
    logic              collide_clr = 1'b0;
    logic [2:0]        gnt;
    logic              WE;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] write_value;
    logic [1:0]        owner;
    logic [15:0]       collide_cnt;

    wram_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clock(clock), .reset(reset), .req(req), .lock(lock),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .data0(data0), .data1(data1), .data2(data2),
        .gnt(gnt), .WE(WE), .wa(wa), .write_value(write_value), .owner(owner),
        .collide_clr(collide_clr), .collide_cnt(collide_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        int                owner;
        int                collide;
    } exp_t;

    exp_t sb_q[$];

    int                m_owner, m_burst, m_collide;
    bit                m_lockprev;
    logic [ADDR_W-1:0] m_wa;
    logic [DATA_W-1:0] m_wd;
    logic [2:0]        last_req, last_gnt;
    int                n_checks = 0;
    int                n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Picks the requester the rules say should win: locked owner first, else rotation order.
    function automatic int model_pick(input logic [2:0] r, input logic [2:0] l);
        int order[3];
        if (r[m_owner] && l[m_owner] && m_burst < MAX_BURST)
            return m_owner;
        for (int k = 0; k < 3; k++) begin
`ifdef WARB_FIXED_PRIORITY_EN
            order[k] = k;
`else
            order[k] = (m_owner + 1 + k) % 3;
`endif
        end
        for (int k = 0; k < 3; k++)
            if (r[order[k]])
                return order[k];
        return -1;
    endfunction

    task automatic model_reset();
        m_owner    = 2;
        m_burst    = 0;
        m_lockprev = 1'b0;
        m_collide  = 0;
        m_wa       = '0;
        m_wd       = '0;
        last_req   = 3'b000;
        last_gnt   = 3'b000;
        sb_q.delete();
    endtask

    task automatic step(input logic [2:0] r, input logic [2:0] l, input logic clr,
                        input bit rnd, output int g_obs);
        exp_t       e;
        int         g;
        int         pops;
        logic [2:0] exp_gnt;
        @(negedge clock);
        if (rnd) begin
            if (!(last_req[0] && !last_gnt[0])) begin
                addr0 = ADDR_W'($urandom);
                data0 = {$urandom, $urandom, $urandom, $urandom};
            end
            if (!(last_req[1] && !last_gnt[1])) begin
                addr1 = ADDR_W'($urandom);
                data1 = {$urandom, $urandom, $urandom, $urandom};
            end
            if (!(last_req[2] && !last_gnt[2])) begin
                addr2 = ADDR_W'($urandom);
                data2 = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        req = r;
        lock = l;
        collide_clr = clr;
        #1;
        g = model_pick(r, l);
        exp_gnt = (g < 0) ? 3'b000 : 3'(1 << g);
        chk("gnt", 128'(gnt), 128'(exp_gnt));
        case (gnt)
            3'b001:  g_obs = 0;
            3'b010:  g_obs = 1;
            3'b100:  g_obs = 2;
            default: g_obs = -1;
        endcase
        pops = int'(r[0]) + int'(r[1]) + int'(r[2]);
        if (clr)
            m_collide = 0;
        else if (pops >= 2 && m_collide < 65535)
            m_collide++;
        if (g >= 0) begin
            m_burst    = (g != m_owner || !m_lockprev || m_burst >= MAX_BURST) ? 1 : m_burst + 1;
            m_lockprev = l[g];
            m_owner    = g;
            case (g)
                0:       begin m_wa = addr0; m_wd = data0; end
                1:       begin m_wa = addr1; m_wd = data1; end
                default: begin m_wa = addr2; m_wd = data2; end
            endcase
        end else begin
            m_lockprev = m_lockprev && l[m_owner];
        end
        e.we      = (g >= 0);
        e.wa      = m_wa;
        e.wd      = m_wd;
        e.owner   = m_owner;
        e.collide = m_collide;
        sb_q.push_back(e);
        last_req = r;
        last_gnt = gnt;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b0;
        req = 3'b000;
        lock = 3'b000;
        collide_clr = 1'b0;
        model_reset();
        #1;
        chk("rst_we", 128'(WE), 128'(0));
        chk("rst_wa", 128'(wa), 128'(0));
        chk("rst_wv", 128'(write_value), 128'(0));
        chk("rst_owner", 128'(owner), 128'(2));
        chk("rst_collide", 128'(collide_cnt), 128'(0));
        chk("rst_gnt", 128'(gnt), 128'(0));
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    // Monitor: each registered output is compared against the oldest expected entry.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #2;
            if (reset && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("mon_we", 128'(WE), 128'(e.we));
                if (e.we) begin
                    chk("mon_wa", 128'(wa), 128'(e.wa));
                    chk("mon_wv", 128'(write_value), 128'(e.wd));
                end
                chk("mon_owner", 128'(owner), 128'(e.owner));
                chk("mon_collide", 128'(collide_cnt), 128'(e.collide));
            end
        end
    end

    initial begin : driver
        int g;
        int seq2[6];
        int seq3[7];
        logic [2:0] r;
        seq2 = '{0, 1, 2, 0, 1, 2};
        seq3 = '{0, 1, 1, 1, 1, 0, 1};

        apply_reset();
        addr0 = 13'h0A5;
        data0 = 128'h1;
        step(3'b001, 3'b000, 1'b0, 1'b0, g);
        chk("t1_gnt", 128'(g), 128'(0));
        @(posedge clock);
        #1;
        chk("t1_we", 128'(WE), 128'(1));
        chk("t1_wa", 128'(wa), 128'(13'h0A5));
        chk("t1_wv", 128'(write_value), 128'(1));
        chk("t1_owner", 128'(owner), 128'(0));

        apply_reset();
        for (int k = 0; k < 6; k++) begin
            step(3'b111, 3'b000, 1'b0, 1'b1, g);
`ifdef WARB_FIXED_PRIORITY_EN
            chk("t2_seq", 128'(g), 128'(0));
`else
            chk("t2_seq", 128'(g), 128'(seq2[k]));
`endif
        end
        @(posedge clock);
        #1;
        chk("t2_collide", 128'(collide_cnt), 128'(6));

`ifndef WARB_FIXED_PRIORITY_EN
        apply_reset();
        for (int k = 0; k < 7; k++) begin
            step(3'b011, (k == 0) ? 3'b000 : 3'b010, 1'b0, 1'b1, g);
            chk("t3_seq", 128'(g), 128'(seq3[k]));
        end
`endif

        apply_reset();
        for (int k = 0; k < 10; k++) begin
            step(3'b100, 3'b100, 1'b0, 1'b1, g);
            chk("t4_seq", 128'(g), 128'(2));
        end

        apply_reset();
        for (int k = 0; k < 65534; k++)
            step(3'b110, 3'b000, 1'b0, 1'b0, g);
        @(posedge clock);
        #1;
        chk("t5_fffe", 128'(collide_cnt), 128'(16'hFFFE));
        for (int k = 0; k < 3; k++)
            step(3'b110, 3'b000, 1'b0, 1'b0, g);
        @(posedge clock);
        #1;
        chk("t5_sat", 128'(collide_cnt), 128'(16'hFFFF));
        step(3'b110, 3'b000, 1'b1, 1'b0, g);
        @(posedge clock);
        #1;
        chk("t5_clr", 128'(collide_cnt), 128'(0));

        apply_reset();
        for (int k = 0; k < 3; k++)
            step(3'b100, 3'b100, 1'b0, 1'b1, g);
        @(posedge clock);
        #1;
        chk("t6_we_before", 128'(WE), 128'(1));
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("t6_we", 128'(WE), 128'(0));
        chk("t6_gnt", 128'(gnt), 128'(0));
        chk("t6_owner", 128'(owner), 128'(2));
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        step(3'b000, 3'b000, 1'b0, 1'b1, g);
        @(posedge clock);
        #1;
        chk("t6_no_write", 128'(WE), 128'(0));

`ifdef WARB_FIXED_PRIORITY_EN
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            step(3'b111, 3'b000, 1'b0, 1'b1, g);
            chk("fp_seq", 128'(g), 128'(0));
        end
`endif

        apply_reset();
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 3; i++) begin
                if (last_req[i] && !last_gnt[i] && $urandom_range(7) != 0)
                    r[i] = 1'b1;
                else
                    r[i] = ($urandom_range(1) == 1);
            end
            step(r, 3'($urandom_range(7)), ($urandom_range(31) == 0), 1'b1, g);
        end

        repeat (2) @(posedge clock);
        #3;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
